// File: rtl/counter_dn_8b.sv
// Loadable down counter with optional auto-reload on underflow, a cascadable
// borrow output and a registered one-cycle pulse on the 1 -> 0 decrement.
module counter_dn_8b #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             p_en,
    input  logic             t_en,
    input  logic             ld_n,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ripple_borrow_out,
    output logic             zero,
    output logic             done
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;

    logic             w_cnt_en;
    logic             w_zero;
    logic             w_one;

    assign w_cnt_en = p_en & t_en;
    assign w_zero   = (r_count == '0);
    assign w_one    = (r_count == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!ld_n) begin
                r_count  <= data_in;
                r_reload <= data_in;
            end else if (w_cnt_en) begin
                if (!w_zero) begin
                    r_count <= r_count - WIDTH'(1);
                    r_done  <= w_one;
                end else if (auto_reload) begin
                    // A zero reload value simply parks the count at 0.
                    r_count <= r_reload;
                end else begin
                    r_count <= '1;
                end
            end
        end
    end

    assign data_out          = r_count;
    assign zero              = w_zero;
    // Borrow ignores p_en so it can drive the next stage's t_en.
    assign ripple_borrow_out = t_en & w_zero;
    assign done              = r_done;

endmodule

// File: tb/tb_counter_dn_8b.sv
// Bench for counter_dn_8b: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an arithmetic model.
module tb_counter_dn_8b;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       p_en = 1'b0;
    logic       t_en = 1'b0;
    logic       ld_n = 1'b1;
    logic       auto_reload = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       ripple_borrow_out;
    logic       zero;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    counter_dn_8b #(.WIDTH(8)) dut (
        .clk               (clk),
        .clr               (clr),
        .p_en              (p_en),
        .t_en              (t_en),
        .ld_n              (ld_n),
        .auto_reload       (auto_reload),
        .data_in           (data_in),
        .data_out          (data_out),
        .ripple_borrow_out (ripple_borrow_out),
        .zero              (zero),
        .done              (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integers, updated from the inputs sampled at each edge.
    int m_count  = 0;
    int m_reload = 0;
    int m_done   = 0;
    bit m_valid  = 1'b0;

    always begin
        @(posedge clk);
        begin
            int nxt;
            int was;
            was = m_count;
            nxt = m_count;
            m_done = 0;
            if (clr) begin
                nxt = 0;
                m_reload = 0;
                m_valid = 1'b1;
            end else if (!ld_n) begin
                nxt = data_in;
                m_reload = data_in;
            end else if (p_en && t_en) begin
                if (was > 0) nxt = was - 1;
                else if (auto_reload) nxt = m_reload;
                else nxt = 255;
                m_done = (was == 1) ? 1 : 0;
            end
            m_count = nxt;
        end
        #1;
        if (m_valid) begin
            chk("model_data_out", data_out, m_count);
            chk("model_zero", zero, (m_count == 0) ? 1 : 0);
            chk("model_borrow", ripple_borrow_out, (t_en && m_count == 0) ? 1 : 0);
            chk("model_done", done, m_done);
        end
    end

    task automatic apply(input bit c, input bit l_n, input bit p, input bit t,
                         input bit a, input logic [7:0] d);
        @(negedge clk);
        clr = c; ld_n = l_n; p_en = p; t_en = t; auto_reload = a; data_in = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Clear then load
        apply(1, 1, 0, 0, 0, 8'h00); tick();
        chk("rst_data", data_out, 8'h00);
        chk("rst_zero", zero, 1);
        chk("rst_done", done, 0);
        chk("rst_borrow_t0", ripple_borrow_out, 0);
        apply(0, 0, 0, 1, 0, 8'h05); tick();
        chk("load05_data", data_out, 8'h05);
        chk("load05_zero", zero, 0);

        // Countdown from 3 with done pulse, then wrap
        apply(0, 0, 0, 0, 0, 8'h03); tick();
        apply(0, 1, 1, 1, 0, 8'h00); tick();
        chk("cd_02", data_out, 8'h02);
        chk("cd_02_done", done, 0);
        tick();
        chk("cd_01", data_out, 8'h01);
        tick();
        chk("cd_00", data_out, 8'h00);
        chk("cd_00_done", done, 1);
        chk("cd_00_borrow", ripple_borrow_out, 1);
        tick();
        chk("wrap_ff", data_out, 8'hFF);
        chk("wrap_done", done, 0);

        // Auto-reload: load 2 (load beats count), then 01, 00, 02
        apply(0, 0, 1, 1, 1, 8'h02); tick();
        chk("ar_load", data_out, 8'h02);
        apply(0, 1, 1, 1, 1, 8'h00); tick();
        chk("ar_01", data_out, 8'h01);
        tick();
        chk("ar_00", data_out, 8'h00);
        chk("ar_00_done", done, 1);
        tick();
        chk("ar_02", data_out, 8'h02);
        chk("ar_02_done", done, 0);

        // Enable gating
        apply(0, 0, 0, 0, 0, 8'h10); tick();
        apply(0, 1, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gate_t0_hold", data_out, 8'h10);
            chk("gate_t0_borrow", ripple_borrow_out, 0);
        end
        apply(0, 1, 0, 1, 0, 8'h00); tick();
        chk("gate_p0_hold", data_out, 8'h10);
        apply(1, 1, 0, 1, 0, 8'h00); tick();
        apply(0, 1, 0, 1, 0, 8'h00); tick();
        chk("gate_zero_hold", data_out, 8'h00);
        chk("gate_zero_borrow", ripple_borrow_out, 1);

        // Auto-reload with a zero reload value parks at 0
        apply(0, 1, 1, 1, 1, 8'h00); tick();
        chk("ar_zero_park", data_out, 8'h00);
        chk("ar_zero_done", done, 0);

        // Priority
        apply(0, 0, 1, 1, 0, 8'hA0); tick();
        chk("prio_load", data_out, 8'hA0);
        apply(1, 0, 1, 1, 0, 8'h55); tick();
        chk("prio_clr", data_out, 8'h00);

        // Clear in the middle of a countdown
        apply(0, 0, 0, 0, 0, 8'h01); tick();
        apply(1, 1, 1, 1, 0, 8'h00); tick();
        chk("midclr_data", data_out, 8'h00);
        chk("midclr_done", done, 0);
        apply(0, 1, 0, 0, 0, 8'h00); tick();
        chk("midclr_done_next", done, 0);

        // Randomized traffic, biased toward small loads so done fires often
        for (int i = 0; i < 2000; i++) begin
            bit c, l, p, t, a;
            logic [7:0] d;
            c = ($urandom_range(0, 63) == 0);
            l = ($urandom_range(0, 7) != 0);
            p = ($urandom_range(0, 3) != 0);
            t = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 1);
            d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            apply(c, l, p, t, a, d);
        end
        apply(0, 1, 0, 0, 0, 8'h00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
